// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared types and constants for the RISC-V run/load
//                sequencer: controller state encoding, halt-cause codes,
//                the SYSTEM-opcode halt instructions and their decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RST_HOLD = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_ECALL   = 2'd1,  // ECALL or EBREAK fetched
    HALT_STOP    = 2'd2,  // external stop
    HALT_TIMEOUT = 2'd3   // RUN cycle limit reached
  } halt_cause_t;

  localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

  // Exact-match decode: only the canonical ECALL/EBREAK encodings halt.
  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_run_controller
//  Description : Run/load sequencer for a single-cycle RISC-V datapath.
//                Streams a program into instruction memory, holds the core
//                in reset for RST_CYCLES, runs it under a clock-enable until
//                ECALL/EBREAK, stop or timeout, then freezes it (reset
//                released) so the register bank can be inspected.
//  Ports       : clk/rst           - clock, synchronous active-high reset
//                load_req/start    - level requests, sampled in IDLE/DONE
//                stop              - abort a run in progress
//                ld_*              - valid/ready program load stream
//                imem_*            - instruction-memory write port
//                instr/pc          - datapath fetch observation
//                core_rstn/core_en - datapath reset and clock-enable
//                busy/done/halt_*  - run status
//                load_words/ovf    - last-load status
//                cycle_count       - RUN cycles including the halting one
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int IMEM_AW    = 10,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               start,
  input  logic               stop,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        instr,
  input  logic [31:0]        pc,
  output logic               core_rstn,
  output logic               core_en,
  output logic               busy,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [31:0]        halt_pc,
  output logic [IMEM_AW:0]   load_words,
  output logic               load_ovf,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int                 c_hold_w       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(RST_CYCLES - 1);
  localparam bit                 c_timeout_en   = (MAX_CYCLES != 0);
  // Timeout is judged on the pre-increment count so that the limit cycle
  // itself still executes with core_en high.
  localparam logic [CNT_W-1:0]   c_timeout_last = CNT_W'(MAX_CYCLES - 1);

  ctrl_state_t         r_state;
  ctrl_state_t         w_next_state;
  logic [IMEM_AW-1:0]  r_wptr;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [CNT_W-1:0]    r_cycle_count;
  logic [IMEM_AW:0]    r_load_words;
  logic                r_load_ovf;
  logic                r_core_rstn;
  logic                r_busy;
  logic                r_done;
  halt_cause_t         r_halt_cause;
  logic [31:0]         r_halt_pc;

  logic                w_halt;
  logic                w_ld_ready;
  logic                w_handshake;
  logic                w_wptr_last;
  logic                w_core_en;
  halt_cause_t         w_exit_cause;

  assign w_halt      = is_halt_instr(instr);
  assign w_handshake = ld_valid & w_ld_ready;
  assign w_wptr_last = &r_wptr;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (load_req) begin
          w_next_state = ST_LOAD;
        end else if (start) begin
          w_next_state = ST_RST_HOLD;
        end
      end
      ST_LOAD: begin
        // Either the stream ends or memory is full; an overflowing stream
        // is left un-drained for the host to notice via load_ovf.
        if (w_handshake && (ld_last || w_wptr_last)) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RST_HOLD: begin
        if (r_hold_cnt == c_hold_last) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_exit_cause != HALT_NONE) begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ combinational outs
  always_comb begin
    w_ld_ready   = (r_state == ST_LOAD);
    // Dropping the enable in the halting cycle keeps ECALL/EBREAK (and the
    // instruction under a stop) from committing.
    w_core_en    = (r_state == ST_RUN) && !w_halt && !stop;
    w_exit_cause = HALT_NONE;
    if (r_state == ST_RUN) begin
      if (w_halt) begin
        w_exit_cause = HALT_ECALL;
      end else if (stop) begin
        w_exit_cause = HALT_STOP;
      end else if (c_timeout_en && (r_cycle_count == c_timeout_last)) begin
        w_exit_cause = HALT_TIMEOUT;
      end
    end
  end

  assign ld_ready   = w_ld_ready;
  assign imem_we    = w_handshake;
  assign imem_waddr = r_wptr;
  assign imem_wdata = ld_data;
  assign core_en    = w_core_en;

  // ------------------------------------------------- counters and status regs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_hold_cnt    <= '0;
      r_cycle_count <= '0;
      r_load_words  <= '0;
      r_load_ovf    <= 1'b0;
      r_core_rstn   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_halt_cause  <= HALT_NONE;
      r_halt_pc     <= '0;
    end else begin
      // Registered from the next state so they line up with r_state.
      r_core_rstn <= (w_next_state == ST_RUN) || (w_next_state == ST_DONE);
      r_busy      <= (w_next_state == ST_LOAD) || (w_next_state == ST_RST_HOLD) ||
                     (w_next_state == ST_RUN);
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (load_req) begin
            r_wptr       <= '0;
            r_load_words <= '0;
            r_load_ovf   <= 1'b0;
            r_done       <= 1'b0;
          end else if (start) begin
            r_done        <= 1'b0;
            r_halt_cause  <= HALT_NONE;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_handshake) begin
            r_wptr       <= r_wptr + 1'b1;
            r_load_words <= {1'b0, r_wptr} + 1'b1;
            if (!ld_last && w_wptr_last) begin
              r_load_ovf <= 1'b1;
            end
          end
        end
        ST_RST_HOLD: begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        ST_RUN: begin
          if (r_cycle_count != '1) begin
            r_cycle_count <= r_cycle_count + 1'b1;
          end
          if (w_exit_cause != HALT_NONE) begin
            r_done       <= 1'b1;
            r_halt_cause <= w_exit_cause;
            r_halt_pc    <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rstn   = r_core_rstn;
  assign busy        = r_busy;
  assign done        = r_done;
  assign halt_cause  = r_halt_cause;
  assign halt_pc     = r_halt_pc;
  assign load_words  = r_load_words;
  assign load_ovf    = r_load_ovf;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
